// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: instruction-memory load/read ports plus the decode/execute handshake.
// The master modport is the fetch controller; the slave modport is the memory/decode side.
interface instr_fetch_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
);
   logic              fin_file;
   logic [DATA_W-1:0] return_instr_line;
   logic              read_file;
   logic              read_memory;
   logic [ADDR_W-1:0] pos;
   logic              fetch_en;
   logic              instr_ready;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              load_done;
   logic [ADDR_W:0]   prog_len;
   logic              load_overflow;
   logic              done;

   modport master (
      input  fin_file, return_instr_line, fetch_en, instr_ready, branch_taken, branch_target,
      output read_file, read_memory, pos, instr, instr_pc, instr_valid,
             load_done, prog_len, load_overflow, done
   );

   modport slave (
      output fin_file, return_instr_line, fetch_en, instr_ready, branch_taken, branch_target,
      input  read_file, read_memory, pos, instr, instr_pc, instr_valid,
             load_done, prog_len, load_overflow, done
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch controller: loads the program file into instruction memory, then
// streams instructions to decode over a valid/ready handshake with branch redirects.
module instr_fetch #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 16,
   parameter int MEM_DEPTH = 400
) (
   input  logic           clk,
   input  logic           rst,
   instr_fetch_if.master  bus
);
   typedef enum logic [0:0] {S_LOAD, S_FETCH} state_t;

   localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_instr_pc;
   logic [ADDR_W:0]   r_prog_len;
   logic              r_instr_valid;
   logic              r_load_overflow;
   logic              w_read_file;
   logic              w_issue;
   logic              w_overflow_hit;
   logic              w_pc_in_range;
   logic [DATA_W-1:0] w_instr;

   assign w_pc_in_range = ({1'b0, r_pc} < r_prog_len);

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_state   = r_state;
      w_read_file    = 1'b0;
      w_issue        = 1'b0;
      w_overflow_hit = 1'b0;
      case (r_state)
         S_LOAD: begin
            // rst gates the request so nothing is asked of memory while reset is held
            w_read_file = rst & ~bus.fin_file & (r_prog_len < DEPTH);
            if (bus.fin_file) begin
               w_next_state = S_FETCH;
            end else if (r_prog_len >= DEPTH) begin
               w_overflow_hit = 1'b1;
               w_next_state   = S_FETCH;
            end
         end
         S_FETCH: begin
            w_issue = bus.fetch_en & ~bus.branch_taken & w_pc_in_range &
                      (~r_instr_valid | bus.instr_ready);
         end
         default: w_next_state = S_LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_LOAD;
      else      r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc            <= '0;
         r_instr_pc      <= '0;
         r_prog_len      <= '0;
         r_instr_valid   <= 1'b0;
         r_load_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_read_file)    r_prog_len      <= r_prog_len + LEN_ONE;
               if (w_overflow_hit) r_load_overflow <= 1'b1;
            end
            S_FETCH: begin
               // redirect squashes whatever is presented, even if decode accepts it this cycle
               if (bus.branch_taken) begin
                  r_pc          <= bus.branch_target;
                  r_instr_valid <= 1'b0;
               end else if (w_issue) begin
                  r_pc          <= r_pc + PC_ONE;
                  r_instr_pc    <= r_pc;
                  r_instr_valid <= 1'b1;
               end else if (r_instr_valid && bus.instr_ready) begin
                  r_instr_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // memory holds its read data while read_memory is low, so instr stays stable on a stall
   assign w_instr           = bus.return_instr_line;
   assign bus.instr         = w_instr;
   assign bus.read_file     = w_read_file;
   assign bus.read_memory   = w_issue;
   assign bus.pos           = r_pc;
   assign bus.instr_pc      = r_instr_pc;
   assign bus.instr_valid   = r_instr_valid;
   assign bus.load_done     = (r_state == S_FETCH);
   assign bus.prog_len      = r_prog_len;
   assign bus.load_overflow = r_load_overflow;
   assign bus.done          = (r_state == S_FETCH) & ~w_pc_in_range & ~r_instr_valid;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural instruction memory and file source.
module tb_instr_fetch;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   instr_fetch_if bus ();

   instr_fetch #(.ADDR_W(9), .DATA_W(16), .MEM_DEPTH(400)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // File source and instruction memory: fin_file rises on the edge that stores the last line.
   logic [15:0] file_data [512];
   logic [15:0] mem       [512];
   int          file_len;
   int          load_cnt;
   int          rf_cnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_cnt                  <= 0;
         rf_cnt                    <= 0;
         bus.fin_file              <= 1'b0;
         bus.return_instr_line     <= '0;
      end else begin
         if (bus.read_file) begin
            mem[load_cnt] <= file_data[load_cnt];
            load_cnt      <= load_cnt + 1;
            rf_cnt        <= rf_cnt + 1;
            if (load_cnt + 1 == file_len) bus.fin_file <= 1'b1;
         end
         if (bus.read_memory) bus.return_instr_line <= mem[bus.pos];
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_and_load(input int len, input int bound);
      file_len = len;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int k = 0; k < bound; k++) begin
         if (bus.load_done) break;
         step();
      end
      check("load_reached", 32'(bus.load_done), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst               = 1'b0;
      bus.fetch_en      = 1'b0;
      bus.instr_ready   = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      file_len          = 5;
      for (int i = 0; i < 512; i++) file_data[i] = 16'((i + 1) * 16'h1111);
      #2;

      check("rst_read_file",   32'(bus.read_file), 0);
      check("rst_read_memory", 32'(bus.read_memory), 0);
      check("rst_load_done",   32'(bus.load_done), 0);
      check("rst_done",        32'(bus.done), 0);
      check("rst_prog_len",    32'(bus.prog_len), 0);
      check("rst_valid",       32'(bus.instr_valid), 0);

      // 5-line load, fetch disabled
      reset_and_load(5, 50);
      check("ld5_reads",     32'(rf_cnt), 5);
      check("ld5_prog_len",  32'(bus.prog_len), 5);
      check("ld5_read_file", 32'(bus.read_file), 0);
      check("ld5_read_mem",  32'(bus.read_memory), 0);
      check("ld5_overflow",  32'(bus.load_overflow), 0);

      // straight-line fetch of 3 instructions
      bus.fetch_en    = 1'b1;
      bus.instr_ready = 1'b1;
      reset_and_load(3, 50);
      check("f3_read_mem", 32'(bus.read_memory), 1);
      check("f3_pos0",     32'(bus.pos), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("f3_valid",    32'(bus.instr_valid), 1);
         check("f3_instr",    32'(bus.instr), 32'((i + 1) * 32'h1111));
         check("f3_instr_pc", 32'(bus.instr_pc), 32'(i));
      end
      step();
      check("f3_valid_end", 32'(bus.instr_valid), 0);
      check("f3_done",      32'(bus.done), 1);
      check("f3_read_end",  32'(bus.read_memory), 0);

      // stall with instr_pc=1
      reset_and_load(3, 50);
      step();
      step();
      check("st_pc1", 32'(bus.instr_pc), 1);
      bus.instr_ready = 1'b0;
      #1;
      check("st_read_mem", 32'(bus.read_memory), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("st_instr",    32'(bus.instr), 32'h2222);
         check("st_instr_pc", 32'(bus.instr_pc), 1);
         check("st_pos",      32'(bus.pos), 2);
         check("st_rd",       32'(bus.read_memory), 0);
      end
      bus.instr_ready = 1'b1;
      #1;
      check("st_rel_rd", 32'(bus.read_memory), 1);
      step();
      check("st_rel_pc",    32'(bus.instr_pc), 2);
      check("st_rel_instr", 32'(bus.instr), 32'h3333);

      // branch to 0 while instr_pc=2 valid and accepted
      bus.branch_taken  = 1'b1;
      bus.branch_target = 9'd0;
      #1;
      check("br_no_read", 32'(bus.read_memory), 0);
      step();
      check("br_squash", 32'(bus.instr_valid), 0);
      check("br_pos",    32'(bus.pos), 0);
      bus.branch_taken = 1'b0;
      #1;
      check("br_reissue", 32'(bus.read_memory), 1);
      step();
      check("br_instr_pc", 32'(bus.instr_pc), 0);
      check("br_instr",    32'(bus.instr), 32'h1111);
      check("br_valid",    32'(bus.instr_valid), 1);
      step();
      step();
      step();
      check("br_done", 32'(bus.done), 1);

      // out-of-range branch, then back in range
      bus.branch_taken  = 1'b1;
      bus.branch_target = 9'd5;
      step();
      bus.branch_taken = 1'b0;
      #1;
      check("oor_pos",  32'(bus.pos), 5);
      check("oor_done", 32'(bus.done), 1);
      check("oor_rd",   32'(bus.read_memory), 0);
      bus.branch_taken  = 1'b1;
      bus.branch_target = 9'd1;
      step();
      bus.branch_taken = 1'b0;
      #1;
      check("inr_done", 32'(bus.done), 0);
      check("inr_rd",   32'(bus.read_memory), 1);
      step();
      check("inr_instr", 32'(bus.instr), 32'h2222);
      step();
      check("inr_pc2", 32'(bus.instr_pc), 2);
      check("inr_pos", 32'(bus.pos), 3);

      // asynchronous reset mid-FETCH
      rst = 1'b0;
      #1;
      check("mr_valid",     32'(bus.instr_valid), 0);
      check("mr_instr_pc",  32'(bus.instr_pc), 0);
      check("mr_prog_len",  32'(bus.prog_len), 0);
      check("mr_load_done", 32'(bus.load_done), 0);
      check("mr_read_file", 32'(bus.read_file), 0);
      check("mr_read_mem",  32'(bus.read_memory), 0);
      check("mr_pos",       32'(bus.pos), 0);
      @(negedge clk);
      rst          = 1'b1;
      bus.fetch_en = 1'b0;
      #1;
      check("mr_rel_read_file", 32'(bus.read_file), 1);
      step();
      check("mr_rel_prog_len", 32'(bus.prog_len), 1);

      // fetch_en gates issue but not a pending handshake
      for (int k = 0; k < 20 && !bus.load_done; k++) step();
      check("fe_load_done", 32'(bus.load_done), 1);
      check("fe_no_read",   32'(bus.read_memory), 0);
      step();
      check("fe_idle_valid", 32'(bus.instr_valid), 0);
      bus.fetch_en = 1'b1;
      step();
      check("fe_issue_valid", 32'(bus.instr_valid), 1);
      bus.fetch_en    = 1'b0;
      bus.instr_ready = 1'b0;
      step();
      check("fe_hold_valid", 32'(bus.instr_valid), 1);
      bus.instr_ready = 1'b1;
      step();
      check("fe_drain_valid", 32'(bus.instr_valid), 0);
      check("fe_drain_pos",   32'(bus.pos), 1);

      // overflow: file longer than the memory
      reset_and_load(410, 1000);
      check("ov_reads",     32'(rf_cnt), 400);
      check("ov_prog_len",  32'(bus.prog_len), 400);
      check("ov_flag",      32'(bus.load_overflow), 1);
      check("ov_read_file", 32'(bus.read_file), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
